// File: rtl/row_buffer_5_pkg.sv
`default_nettype none
// ============================================================================
// row_buffer_5_pkg : shared constants and helpers for the 5-row line buffer
// Revision: 1.0
// ============================================================================
package row_buffer_5_pkg;

    localparam int NUM_TAPS = 5;
    localparam int PIX_W    = 8;
    localparam int ROW_BITS = 3;

    typedef logic [PIX_W-1:0]    pixel_t;
    typedef logic [ROW_BITS-1:0] row_t;

    localparam row_t LAST_ROW = ROW_BITS'(NUM_TAPS - 1);

    // Bank index one step ahead, wrapping at NUM_TAPS. Also gives hsel for the
    // bank being written: the centre row then sits at (2 + hsel) mod 5.
    function automatic row_t next_row(input row_t r);
        return (r == LAST_ROW) ? '0 : r + row_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_buffer_5_line.sv
`default_nettype none
// ============================================================================
// line_ram : single-port row bank, synchronous read, one pixel per column
// Revision: 1.0
// ============================================================================
module line_ram
    import row_buffer_5_pkg::*;
#(
    parameter int WIDTH     = 640,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  pixel_t               wdata,
    output pixel_t               rdata
);

    pixel_t mem [WIDTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/row_buffer_5.sv
`default_nettype none
// ============================================================================
// row_buffer_5 : five-bank circular line buffer feeding the vertical 5-tap stage
// Revision: 1.0
// ============================================================================
module row_buffer_5
    import row_buffer_5_pkg::*;
#(
    parameter int WIDTH     = 640,
    parameter int ADDR_BITS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sof,
    input  pixel_t     din,
    input  logic       validin,
    output pixel_t     dout0,
    output pixel_t     dout1,
    output pixel_t     dout2,
    output pixel_t     dout3,
    output pixel_t     dout4,
    output row_t       hsel,
    output logic       validout
);

    localparam logic [ADDR_BITS-1:0] LAST_COL = ADDR_BITS'(WIDTH - 1);

    logic [ADDR_BITS-1:0] col;
    logic [ADDR_BITS-1:0] last_addr;
    logic [ADDR_BITS-1:0] eff_col;
    logic [ADDR_BITS-1:0] ram_addr;
    row_t                 wr_row;
    row_t                 rows_done;
    row_t                 eff_row;
    row_t                 eff_done;
    row_t                 byp_row;
    logic                 end_of_row;
    logic                 loaded;
    pixel_t               din_q;
    pixel_t               rdata [NUM_TAPS];
    pixel_t               dout_mux [NUM_TAPS];

    // A frame start restarts the position before the pixel is placed.
    always_comb begin
        eff_col    = sof ? '0 : col;
        eff_row    = sof ? '0 : wr_row;
        eff_done   = sof ? '0 : rows_done;
        end_of_row = (eff_col == LAST_COL);
        // Idle cycles re-read the last address so bank outputs hold.
        ram_addr   = validin ? eff_col : last_addr;
    end

    generate
        for (genvar k = 0; k < NUM_TAPS; k++) begin : g_bank
            line_ram #(
                .WIDTH     (WIDTH),
                .ADDR_BITS (ADDR_BITS)
            ) u_line_ram (
                .clock (clock),
                .we    (validin && (eff_row == ROW_BITS'(k))),
                .addr  (ram_addr),
                .wdata (din),
                .rdata (rdata[k])
            );
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col       <= '0;
            wr_row    <= '0;
            rows_done <= '0;
            last_addr <= '0;
            byp_row   <= '0;
            din_q     <= '0;
            loaded    <= 1'b0;
            hsel      <= '0;
            validout  <= 1'b0;
        end else begin
            validout <= 1'b0;
            if (validin) begin
                last_addr <= eff_col;
                byp_row   <= eff_row;
                din_q     <= din;
                loaded    <= 1'b1;
                hsel      <= next_row(eff_row);
                validout  <= (eff_done == LAST_ROW);
                if (end_of_row) begin
                    col       <= '0;
                    wr_row    <= next_row(eff_row);
                    rows_done <= (eff_done == LAST_ROW) ? LAST_ROW : eff_done + row_t'(1);
                end else begin
                    col       <= eff_col + ADDR_BITS'(1);
                    wr_row    <= eff_row;
                    rows_done <= eff_done;
                end
            end
        end
    end

    // The bank just written cannot return the new pixel, so it is bypassed.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            dout_mux[k] = '0;
            if (loaded) begin
                dout_mux[k] = (byp_row == ROW_BITS'(k)) ? din_q : rdata[k];
            end
        end
    end

    assign dout0 = dout_mux[0];
    assign dout1 = dout_mux[1];
    assign dout2 = dout_mux[2];
    assign dout3 = dout_mux[3];
    assign dout4 = dout_mux[4];

endmodule
`default_nettype wire
